sent_rx_crc_check_fast: RTL
===========================

SENT_RX_CRC_CHECK_FAST -- requirements
Module: sent_rx_crc_check_fast

Interface
REQ-001 SHALL have port clk_rx, input, 1, receive clock; all logic on rising edge only; one clock domain.
REQ-002 SHALL have port reset, input, 1, reset; asynchronous and active-low (asserted at 0).
REQ-003 SHALL have port enable_crc_check_fast6, input, 1, one-cycle start pulse: check a 6-data-nibble fast frame.
REQ-004 SHALL have port enable_crc_check_fast4, input, 1, one-cycle start pulse: check a 4-data-nibble fast frame.
REQ-005 SHALL have port enable_crc_check_fast3, input, 1, one-cycle start pulse: check a 3-data-nibble fast frame.
REQ-006 SHALL have port data_nibbles_in, input, 24, received data nibbles with D1 in [23:20] through D6 in [3:0]; only valid in the enable cycle.
REQ-007 SHALL have port crc_in, input, 4, received CRC nibble; only valid in the enable cycle.
REQ-008 SHALL have port valid_data_fast, output, 1, one-cycle pulse: CRC matched and data_fast is valid.
REQ-009 SHALL have port data_fast, output, 24, checked data, left-aligned (D1 in [23:20]), with unused nibbles set to 0.
REQ-010 SHALL have port crc_error_fast, output, 1, one-cycle pulse: CRC mismatch.
REQ-011 SHALL have port busy_fast, output, 1, high while a check is in progress.
REQ-012 SHALL have port overrun_fast, output, 1, one-cycle pulse: an enable arrived while busy and was dropped.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC, FINAL and CHECK; all outputs are registered.
REQ-014 In IDLE, on the edge that samples any enable, the block SHALL latch data_nibbles_in and crc_in, set nibble count n (6, 4 or 3), set crc_reg=4'b0101, and go to CALC.
REQ-015 When more than one enable is high in the same cycle, fast6 SHALL take priority over fast4, and fast4 over fast3; the lower-priority enables are ignored and SHALL NOT raise overrun.
REQ-016 In CALC, each edge SHALL process one nibble, D1 first: crc_reg = T[crc_reg] XOR nibble.
- T = {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}, which is polynomial x^4+x^3+x^2+1.
- After n edges, the FSM goes to FINAL.
REQ-017 In FINAL, one edge SHALL apply the zero-nibble augmentation: crc_reg = T[crc_reg]; the FSM then goes to CHECK.
REQ-018 In CHECK, one edge SHALL compare crc_reg with the latched crc_in and return to IDLE.
- On a match: valid_data_fast=1 and data_fast=latched nibbles with unused nibbles masked to 0.
- On a mismatch: crc_error_fast=1 and data_fast is unchanged.
REQ-019 Latency SHALL be fixed: with the enable sampled at edge N, the result pulse is asserted from edge N+n+2 for exactly one cycle. This is 8 cycles for fast6, 6 for fast4 and 5 for fast3.
REQ-020 busy_fast SHALL be 1 from edge N through edge N+n+1, and SHALL be 0 from edge N+n+2.
REQ-021 Any enable sampled while busy_fast=1 SHALL be dropped and SHALL produce a one-cycle overrun_fast pulse; the check in progress continues unaffected.
REQ-022 A new enable sampled at edge N+n+3 or later SHALL be accepted normally, giving a back-to-back throughput of one frame per n+3 cycles.
REQ-023 valid_data_fast and crc_error_fast SHALL never be 1 in the same cycle.
REQ-024 data_fast SHALL hold its last valid value until the next successful check.
REQ-025 The nibble counter SHALL be 3 bits wide and SHALL count 0..n-1 without wrap-around.

Reset
REQ-026 While reset=0, the block SHALL immediately and asynchronously force the following, and SHALL ignore all inputs:
- state IDLE;
- crc_reg, counter and latched data to 0;
- data_fast=0, valid_data_fast=0, crc_error_fast=0, busy_fast=0, overrun_fast=0.
REQ-027 A reset asserted mid-check SHALL abort the check with no result pulse.
REQ-028 The first enable sampled on or after the first rising edge following reset release SHALL be accepted.

Verification
REQ-029 Bench scenario: fast6 enable, nibbles 24'h000000, crc_in=5 -> valid_data_fast pulse 8 cycles later, data_fast=24'h000000, crc_error_fast stays 0.
REQ-030 Bench scenario: fast3 enable, nibbles 24'h123ABC, crc_in=0 -> valid_data_fast after 5 cycles, data_fast=24'h123000.
REQ-031 Bench scenario: fast6 enable, nibbles 24'h000000, crc_in=4 -> crc_error_fast pulse 8 cycles later, valid_data_fast stays 0, data_fast unchanged.
REQ-032 Bench scenario: fast6 and fast3 enables in the same cycle -> a 6-nibble check runs (8-cycle latency) and overrun_fast stays 0.
REQ-033 Bench scenario: fast4 enable 2 cycles after a fast6 enable -> overrun_fast pulse, the first check completes normally, and no second result is produced.
REQ-034 Bench scenario: reset=0 asserted 3 cycles into a fast6 check -> all outputs 0 immediately, no result pulse; after release, the next enable gives a normal result.

Source files
------------

// File: rtl/sent_rx_crc_check_fast.sv
// SENT fast-channel CRC checker: runs the 4-bit SENT CRC over 3, 4 or 6 data
// nibbles with a fixed latency and reports a match or a mismatch.
module sent_rx_crc_check_fast (
    input  logic        clk_rx,
    input  logic        reset,
    input  logic        enable_crc_check_fast6,
    input  logic        enable_crc_check_fast4,
    input  logic        enable_crc_check_fast3,
    input  logic [23:0] data_nibbles_in,
    input  logic [3:0]  crc_in,
    output logic        valid_data_fast,
    output logic [23:0] data_fast,
    output logic        crc_error_fast,
    output logic        busy_fast,
    output logic        overrun_fast
);

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned DATA_W = 24;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {IDLE, CALC, FINAL, CHECK} state_t;

    state_t              state, state_d;
    logic [NIB_W-1:0]    crc_reg, crc_reg_d;
    logic [NIB_W-1:0]    crc_lat, crc_lat_d;
    logic [DATA_W-1:0]   data_lat, data_lat_d;
    logic [DATA_W-1:0]   data_fast_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [CNT_W-1:0]    n_reg, n_d;
    logic [NIB_W-1:0]    nib;
    logic                valid_d, err_d, busy_d, overrun_d, any_en;

    // Table form of one CRC step for x^4+x^3+x^2+1
    function automatic logic [NIB_W-1:0] crc_step(input logic [NIB_W-1:0] c);
        logic [NIB_W-1:0] t;
        case (c)
            4'd0:  t = 4'd0;   4'd1:  t = 4'd13;  4'd2:  t = 4'd7;   4'd3:  t = 4'd10;
            4'd4:  t = 4'd14;  4'd5:  t = 4'd3;   4'd6:  t = 4'd9;   4'd7:  t = 4'd4;
            4'd8:  t = 4'd1;   4'd9:  t = 4'd12;  4'd10: t = 4'd6;   4'd11: t = 4'd11;
            4'd12: t = 4'd15;  4'd13: t = 4'd2;   4'd14: t = 4'd8;   default: t = 4'd5;
        endcase
        return t;
    endfunction

    function automatic logic [DATA_W-1:0] mask_data(input logic [DATA_W-1:0] d,
                                                    input logic [CNT_W-1:0]  n);
        logic [DATA_W-1:0] m;
        case (n)
            3'd6:    m = d;
            3'd4:    m = {d[23:8], 8'h00};
            default: m = {d[23:12], 12'h000};
        endcase
        return m;
    endfunction

    assign any_en = enable_crc_check_fast6 | enable_crc_check_fast4 | enable_crc_check_fast3;

    // D1 is processed first, so counter 0 selects the top nibble
    always_comb begin
        case (cnt)
            3'd0:    nib = data_lat[23:20];
            3'd1:    nib = data_lat[19:16];
            3'd2:    nib = data_lat[15:12];
            3'd3:    nib = data_lat[11:8];
            3'd4:    nib = data_lat[7:4];
            3'd5:    nib = data_lat[3:0];
            default: nib = 4'h0;
        endcase
    end

    always_ff @(posedge clk_rx or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            crc_reg         <= '0;
            crc_lat         <= '0;
            data_lat        <= '0;
            cnt             <= '0;
            n_reg           <= '0;
            data_fast       <= '0;
            valid_data_fast <= 1'b0;
            crc_error_fast  <= 1'b0;
            busy_fast       <= 1'b0;
            overrun_fast    <= 1'b0;
        end else begin
            state           <= state_d;
            crc_reg         <= crc_reg_d;
            crc_lat         <= crc_lat_d;
            data_lat        <= data_lat_d;
            cnt             <= cnt_d;
            n_reg           <= n_d;
            data_fast       <= data_fast_d;
            valid_data_fast <= valid_d;
            crc_error_fast  <= err_d;
            busy_fast       <= busy_d;
            overrun_fast    <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state;
        crc_reg_d   = crc_reg;
        crc_lat_d   = crc_lat;
        data_lat_d  = data_lat;
        cnt_d       = cnt;
        n_d         = n_reg;
        data_fast_d = data_fast;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        busy_d      = busy_fast;
        overrun_d   = 1'b0;
        case (state)
            IDLE: begin
                if (any_en) begin
                    data_lat_d = data_nibbles_in;
                    crc_lat_d  = crc_in;
                    n_d        = enable_crc_check_fast6 ? 3'd6 :
                                 enable_crc_check_fast4 ? 3'd4 : 3'd3;
                    crc_reg_d  = 4'b0101;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = CALC;
                end
            end
            CALC: begin
                overrun_d = any_en;
                crc_reg_d = crc_step(crc_reg) ^ nib;
                if (cnt == CNT_W'(n_reg - 3'd1)) begin
                    cnt_d   = '0;
                    state_d = FINAL;
                end else begin
                    cnt_d = CNT_W'(cnt + 3'd1);
                end
            end
            FINAL: begin
                overrun_d = any_en;
                crc_reg_d = crc_step(crc_reg);
                state_d   = CHECK;
            end
            CHECK: begin
                overrun_d = any_en;
                busy_d    = 1'b0;
                state_d   = IDLE;
                if (crc_reg == crc_lat) begin
                    valid_d     = 1'b1;
                    data_fast_d = mask_data(data_lat, n_reg);
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule
